// File: rtl/checksum_arb.sv
// checksum_arb: round-robin arbiter that shares one incremental checksum engine
// among NUM_REQ requesters. Define CSUM_ARB_TIMEOUT_EN to add the WAIT watchdog.
module checksum_arb #(
  parameter int NUM_REQ = 4,
  parameter int CSUM_W  = 16,
  parameter int VAL_W   = 6,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*CSUM_W-1:0] req_old_checksum,
  input  logic [NUM_REQ*VAL_W-1:0]  req_removed_val,
  input  logic [NUM_REQ*VAL_W-1:0]  req_new_val,
  output logic [NUM_REQ-1:0]        done,
  output logic [CSUM_W-1:0]         result,
  output logic                      err,
  output logic                      busy,
  output logic                      eng_req,
  output logic [CSUM_W-1:0]         eng_old_checksum,
  output logic [VAL_W-1:0]          eng_removed_val,
  output logic [VAL_W-1:0]          eng_new_val,
  input  logic                      eng_gnt,
  input  logic [CSUM_W-1:0]         eng_new_checksum
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("checksum_arb: NUM_REQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [CSUM_W-1:0]  old_q, old_d;
  logic [VAL_W-1:0]   rem_q, rem_d;
  logic [VAL_W-1:0]   new_q, new_d;
  logic [CSUM_W-1:0]  res_q, res_d;
  logic [IDX_W-1:0]   win_s;
  logic               found_s;

`ifdef CSUM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
`endif

  // Round-robin search: first set req bit at or above rr_ptr, wrapping.
  always_comb begin
    found_s = 1'b0;
    win_s   = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx     = (int'(rr_ptr_q) + k) % NUM_REQ;
      win_s   = (!found_s && req[idx]) ? IDX_W'(idx) : win_s;
      found_s = found_s | req[idx];
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      old_q    <= '0;
      rem_q    <= '0;
      new_q    <= '0;
      res_q    <= '0;
`ifdef CSUM_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      old_q    <= old_d;
      rem_q    <= rem_d;
      new_q    <= new_d;
      res_q    <= res_d;
`ifdef CSUM_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      err_q    <= err_d;
`endif
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    old_d    = old_q;
    rem_d    = rem_q;
    new_d    = new_q;
    res_d    = res_q;
`ifdef CSUM_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          win_d   = win_s;
          old_d   = req_old_checksum[int'(win_s)*CSUM_W +: CSUM_W];
          rem_d   = req_removed_val[int'(win_s)*VAL_W +: VAL_W];
          new_d   = req_new_val[int'(win_s)*VAL_W +: VAL_W];
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
`ifdef CSUM_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (eng_gnt) begin
          res_d   = eng_new_checksum;
`ifdef CSUM_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = S_RESP;
`ifdef CSUM_ARB_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Watchdog abort hands back the checksum unmodified.
          res_d   = old_q;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_WAIT;
`else
        end else begin
          state_d = S_WAIT;
`endif
        end
      end
      S_RESP: begin
        rr_ptr_d = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    done             = '0;
    err              = 1'b0;
    eng_req          = (state_q == S_ISSUE);
    busy             = (state_q != S_IDLE);
    result           = res_q;
    eng_old_checksum = old_q;
    eng_removed_val  = rem_q;
    eng_new_val      = new_q;
    if (state_q == S_RESP) begin
      done[win_q] = 1'b1;
`ifdef CSUM_ARB_TIMEOUT_EN
      err         = err_q;
`endif
    end else begin
      done = '0;
    end
  end

endmodule

// File: tb/tb_checksum_arb.sv
// Directed testbench for checksum_arb with a 3-cycle incremental-checksum engine model.
module tb_checksum_arb;
  localparam int NUM_REQ = 4;
  localparam int CSUM_W  = 16;
  localparam int VAL_W   = 6;
  localparam int TIMEOUT = 15;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*CSUM_W-1:0] req_old_checksum;
  logic [NUM_REQ*VAL_W-1:0]  req_removed_val;
  logic [NUM_REQ*VAL_W-1:0]  req_new_val;
  logic [NUM_REQ-1:0]        done;
  logic [CSUM_W-1:0]         result;
  logic                      err;
  logic                      busy;
  logic                      eng_req;
  logic [CSUM_W-1:0]         eng_old_checksum;
  logic [VAL_W-1:0]          eng_removed_val;
  logic [VAL_W-1:0]          eng_new_val;
  logic                      eng_gnt;
  logic [CSUM_W-1:0]         eng_new_checksum;

  logic        gnt_model = 1'b0;
  logic        gnt_stray = 1'b0;
  logic        eng_mute  = 1'b0;
  logic [15:0] eng_cs_model = 16'h0000;

  int checks = 0;
  int errors = 0;

  logic [15:0] op_old [4] = '{16'hB861, 16'h1234, 16'hA000, 16'h0F0F};
  logic [5:0]  op_rem [4] = '{6'h05, 6'h01, 6'h0A, 6'h3F};
  logic [5:0]  op_new [4] = '{6'h09, 6'h02, 6'h03, 6'h00};
  logic [15:0] op_exp [4] = '{16'hB851, 16'h1230, 16'hA01C, 16'h100B};

  assign eng_gnt          = gnt_model | gnt_stray;
  assign eng_new_checksum = eng_cs_model;

  checksum_arb #(
    .NUM_REQ(NUM_REQ), .CSUM_W(CSUM_W), .VAL_W(VAL_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .req(req),
    .req_old_checksum(req_old_checksum), .req_removed_val(req_removed_val),
    .req_new_val(req_new_val), .done(done), .result(result), .err(err),
    .busy(busy), .eng_req(eng_req), .eng_old_checksum(eng_old_checksum),
    .eng_removed_val(eng_removed_val), .eng_new_val(eng_new_val),
    .eng_gnt(eng_gnt), .eng_new_checksum(eng_new_checksum)
  );

  always #5 clk = ~clk;

  // Ones-complement update of a 6-bit field sitting at bits [7:2] of a header word.
  function automatic logic [15:0] csum_upd(input logic [15:0] old, input logic [5:0] rem,
                                           input logic [5:0] nw);
    logic [16:0] s;
    s = {1'b0, ~old} + {1'b0, ~{8'h00, rem, 2'b00}};
    s = {1'b0, s[15:0]} + {16'h0000, s[16]};
    s = {1'b0, s[15:0]} + {1'b0, {8'h00, nw, 2'b00}};
    s = {1'b0, s[15:0]} + {16'h0000, s[16]};
    return ~s[15:0];
  endfunction

  // Engine model: gnt three cycles after req, computed from operands at gnt time.
  always begin
    @(negedge clk);
    if (eng_req && !eng_mute) begin
      repeat (3) @(posedge clk);
      #1;
      eng_cs_model = csum_upd(eng_old_checksum, eng_removed_val, eng_new_val);
      gnt_model    = 1'b1;
      @(posedge clk);
      #1;
      gnt_model    = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input string tag, input logic [3:0] exp_done,
                           input logic [15:0] exp_res, input logic exp_err, input int exp_n);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == 4'b0000 && n < 100);
    check({tag, "_done"}, 32'(done), 32'(exp_done));
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_lat"}, 32'(n), 32'(exp_n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic seen;
    reset = 1'b1;
    req   = 4'b0000;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_old_checksum[i*CSUM_W +: CSUM_W] = op_old[i];
      req_removed_val[i*VAL_W +: VAL_W]    = op_rem[i];
      req_new_val[i*VAL_W +: VAL_W]        = op_new[i];
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_done", 32'(done), 32'h0);
    check("rst_result", 32'(result), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_eng_req", 32'(eng_req), 32'h0);
    check("rst_eng_old", 32'(eng_old_checksum), 32'h0);
    check("rst_eng_rem", 32'(eng_removed_val), 32'h0);
    check("rst_eng_new", 32'(eng_new_val), 32'h0);

    gnt_stray = 1'b1;
    @(negedge clk);
    gnt_stray = 1'b0;
    check("stray_gnt_busy", 32'(busy), 32'h0);
    check("stray_gnt_done", 32'(done), 32'h0);

    // Single request with cycle-exact checks.
    req = 4'b0001;
    check("single_c0_eng_req", 32'(eng_req), 32'h0);
    @(negedge clk);
    check("single_c1_eng_req", 32'(eng_req), 32'h1);
    check("single_c1_busy", 32'(busy), 32'h1);
    check("single_c1_eng_old", 32'(eng_old_checksum), 32'hB861);
    check("single_c1_eng_rem", 32'(eng_removed_val), 32'h05);
    check("single_c1_eng_new", 32'(eng_new_val), 32'h09);
    @(negedge clk);
    check("single_c2_eng_req", 32'(eng_req), 32'h0);
    wait_done("single", 4'b0001, 16'hB851, 1'b0, 3);
    req = 4'b0000;
    @(negedge clk);
    check("single_after_done", 32'(done), 32'h0);
    check("single_after_busy", 32'(busy), 32'h0);
    check("single_result_hold", 32'(result), 32'hB851);

    // All four from reset: served 0,1,2,3 at 6-cycle spacing.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req = 4'b1111;
    wait_done("all_r0", 4'b0001, op_exp[0], 1'b0, 5);
    req[0] = 1'b0;
    wait_done("all_r1", 4'b0010, op_exp[1], 1'b0, 6);
    req[1] = 1'b0;
    wait_done("all_r2", 4'b0100, op_exp[2], 1'b0, 6);
    req[2] = 1'b0;
    wait_done("all_r3", 4'b1000, op_exp[3], 1'b0, 6);
    req[3] = 1'b0;

    // Fairness: after requester 2, pending 1010 serves 3 before 1.
    @(negedge clk);
    req = 4'b0100;
    wait_done("fair_r2", 4'b0100, op_exp[2], 1'b0, 5);
    req = 4'b1010;
    wait_done("fair_r3", 4'b1000, op_exp[3], 1'b0, 6);
    req[3] = 1'b0;
    wait_done("fair_r1", 4'b0010, op_exp[1], 1'b0, 6);
    req[1] = 1'b0;

    // Operand stability: live input changes during WAIT must not leak through.
    @(negedge clk);
    req = 4'b0001;
    repeat (2) @(negedge clk);
    req_old_checksum[15:0] = 16'hFFFF;
    @(negedge clk);
    check("stable_eng_old", 32'(eng_old_checksum), 32'hB861);
    wait_done("stable", 4'b0001, 16'hB851, 1'b0, 2);
    req = 4'b0000;
    req_old_checksum[15:0] = op_old[0];

    // Reset in WAIT, then pointer back at 0.
    @(negedge clk);
    eng_mute = 1'b1;
    req = 4'b0010;
    repeat (3) @(negedge clk);
    check("rstmid_busy_before", 32'(busy), 32'h1);
    reset = 1'b1;
    #1;
    check("rstmid_busy", 32'(busy), 32'h0);
    check("rstmid_eng_req", 32'(eng_req), 32'h0);
    check("rstmid_done", 32'(done), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    eng_mute = 1'b0;
    req = 4'b0011;
    wait_done("rstmid_r0", 4'b0001, op_exp[0], 1'b0, 5);
    req[0] = 1'b0;
    wait_done("rstmid_r1", 4'b0010, op_exp[1], 1'b0, 6);
    req[1] = 1'b0;

    // Engine never answers.
    @(negedge clk);
    eng_mute = 1'b1;
    req = 4'b0001;
`ifdef CSUM_ARB_TIMEOUT_EN
    wait_done("timeout", 4'b0001, op_old[0], 1'b1, TIMEOUT + 2);
    req = 4'b0000;
    @(negedge clk);
    check("timeout_err_clear", 32'(err), 32'h0);
`else
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | (done != 4'b0000);
    end
    check("nognt_busy", 32'(busy), 32'h1);
    check("nognt_done_seen", 32'(seen), 32'h0);
    req = 4'b0000;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`endif
    eng_mute = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
